// File: rtl/cvm_pkg.sv
// Shared definitions for the coin vending/change machine: FSM encoding, coin values, select layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (IDLE/PAY/GAP/FIN), coin values in nickel units, one-hot select bit positions,
//           coin_value() which maps a one-hot select to the amount it removes from the balance.
package cvm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Coin values expressed in nickel units.
    localparam logic [4:0] VAL_N = 5'd1;
    localparam logic [4:0] VAL_D = 5'd2;
    localparam logic [4:0] VAL_Q = 5'd5;

    // Bit positions inside the one-hot coin select.
    localparam int SEL_N = 0;
    localparam int SEL_D = 1;
    localparam int SEL_Q = 2;

    typedef logic [2:0] coin_sel_t;

    function automatic logic [4:0] coin_value(input coin_sel_t sel);
        logic [4:0] val;
        val = 5'd0;
        if (sel[SEL_Q]) begin
            val = VAL_Q;
        end else if (sel[SEL_D]) begin
            val = VAL_D;
        end else if (sel[SEL_N]) begin
            val = VAL_N;
        end
        return val;
    endfunction

endpackage

// File: rtl/coin_dispenser_if.sv
// Request/inventory/eject bundle between a host and the coin dispenser.
// Latency: n/a (wiring only).
// Backpressure: host may only present req while ready=1; inv_ld is honoured only while ready=1.
// Ports: req/amt (payout request), inv_ld/inv_n/inv_d/inv_q (inventory load), ready,
//        pn/pd/pq (eject pulses), done/short/rem (completion), cnt_n/cnt_d/cnt_q (inventory).
interface coin_dispenser_if;

    logic       req;
    logic [4:0] amt;
    logic       inv_ld;
    logic [3:0] inv_n;
    logic [3:0] inv_d;
    logic [3:0] inv_q;
    logic       ready;
    logic       pn;
    logic       pd;
    logic       pq;
    logic       done;
    logic       short;
    logic [4:0] rem;
    logic [3:0] cnt_n;
    logic [3:0] cnt_d;
    logic [3:0] cnt_q;

    // Host side.
    modport master (
        output req, amt, inv_ld, inv_n, inv_d, inv_q,
        input  ready, pn, pd, pq, done, short, rem, cnt_n, cnt_d, cnt_q
    );

    // Dispenser side.
    modport slave (
        input  req, amt, inv_ld, inv_n, inv_d, inv_q,
        output ready, pn, pd, pq, done, short, rem, cnt_n, cnt_d, cnt_q
    );

endinterface

// File: rtl/coin_sel.sv
// Greedy coin picker: largest coin that fits the remaining balance and is still in stock.
// Latency: purely combinational.
// Backpressure: none; output is a pure function of the inputs.
// Ports: i_rem (unpaid nickel units), i_cnt_n/d/q (stock) -> o_sel (one-hot Q/D/N), o_none_ok (nothing eligible).
module coin_sel
    import cvm_pkg::*;
(
    input  logic [4:0] i_rem,
    input  logic [3:0] i_cnt_n,
    input  logic [3:0] i_cnt_d,
    input  logic [3:0] i_cnt_q,
    output coin_sel_t  o_sel,
    output logic       o_none_ok
);

    // A coin is eligible only if it does not exceed the balance, so the
    // subtraction in the parent can never underflow.
    always_comb begin
        o_sel = '0;
        if ((i_rem >= VAL_Q) && (i_cnt_q != 4'd0)) begin
            o_sel[SEL_Q] = 1'b1;
        end else if ((i_rem >= VAL_D) && (i_cnt_d != 4'd0)) begin
            o_sel[SEL_D] = 1'b1;
        end else if ((i_rem >= VAL_N) && (i_cnt_n != 4'd0)) begin
            o_sel[SEL_N] = 1'b1;
        end
        o_none_ok = (o_sel == '0);
    end

endmodule

// File: rtl/coin_dispenser.sv
// Change dispenser: pays an amount in nickel units from a Q/D/N inventory, one coin pulse at a time.
// Latency: first pulse one clock after req is accepted, then one coin every two clocks; done follows the last PAY.
// Backpressure: ready=1 only in IDLE; req and inv_ld are ignored at any other time.
// Ports: clk, rst_ (sync, active-low), bus (slave modport: request, inventory load, pulses, done/short/rem, counts).
module coin_dispenser
    import cvm_pkg::*;
(
    input  logic          clk,
    input  logic          rst_,
    coin_dispenser_if.slave bus
);

    state_t     r_state;
    logic [4:0] r_rem;
    logic [3:0] r_cnt_n;
    logic [3:0] r_cnt_d;
    logic [3:0] r_cnt_q;
    logic       r_pn;
    logic       r_pd;
    logic       r_pq;
    logic       r_done;
    logic       r_short;

    coin_sel_t  w_sel;
    logic       w_none_ok;

    coin_sel u_coin_sel (
        .i_rem     (r_rem),
        .i_cnt_n   (r_cnt_n),
        .i_cnt_d   (r_cnt_d),
        .i_cnt_q   (r_cnt_q),
        .o_sel     (w_sel),
        .o_none_ok (w_none_ok)
    );

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
            r_rem   <= 5'd0;
            r_cnt_n <= 4'd0;
            r_cnt_d <= 4'd0;
            r_cnt_q <= 4'd0;
            r_pn    <= 1'b0;
            r_pd    <= 1'b0;
            r_pq    <= 1'b0;
            r_done  <= 1'b0;
            r_short <= 1'b0;
        end else begin
            // Pulses and done are one-cycle strobes; only the arms below raise them.
            r_pn   <= 1'b0;
            r_pd   <= 1'b0;
            r_pq   <= 1'b0;
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.inv_ld) begin
                        // Load takes precedence; a simultaneous req is dropped.
                        r_cnt_n <= bus.inv_n;
                        r_cnt_d <= bus.inv_d;
                        r_cnt_q <= bus.inv_q;
                    end else if (bus.req) begin
                        r_rem   <= bus.amt;
                        r_short <= 1'b0;
                        r_state <= (bus.amt == 5'd0) ? ST_FIN : ST_PAY;
                    end
                end

                ST_PAY: begin
                    if (r_rem == 5'd0) begin
                        r_state <= ST_FIN;
                    end else if (w_none_ok) begin
                        // Stock cannot cover the balance; rem keeps the unpaid part.
                        r_short <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_rem <= r_rem - coin_value(w_sel);
                        if (w_sel[SEL_Q]) begin
                            r_pq    <= 1'b1;
                            r_cnt_q <= r_cnt_q - 4'd1;
                        end else if (w_sel[SEL_D]) begin
                            r_pd    <= 1'b1;
                            r_cnt_d <= r_cnt_d - 4'd1;
                        end else begin
                            r_pn    <= 1'b1;
                            r_cnt_n <= r_cnt_n - 4'd1;
                        end
                        r_state <= ST_GAP;
                    end
                end

                // Spacer cycle so consecutive eject pulses never merge.
                ST_GAP: begin
                    r_state <= ST_PAY;
                end

                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = (r_state == ST_IDLE);
    assign bus.pn    = r_pn;
    assign bus.pd    = r_pd;
    assign bus.pq    = r_pq;
    assign bus.done  = r_done;
    assign bus.short = r_short;
    assign bus.rem   = r_rem;
    assign bus.cnt_n = r_cnt_n;
    assign bus.cnt_d = r_cnt_d;
    assign bus.cnt_q = r_cnt_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed plus randomized bench for coin_dispenser against a closed-form greedy change model.
// Latency: n/a.
// Backpressure: requests are only issued while ready is expected high.
module tb_coin_dispenser;

    logic clk;
    logic rst_;
    int   n_cmp;
    int   n_fail;

    // Reference inventory.
    int   m_n;
    int   m_d;
    int   m_q;

    coin_dispenser_if bus ();

    coin_dispenser dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk_inv(input string tag);
        chk({tag, ".cnt_n"}, 32'(bus.cnt_n), 32'(m_n));
        chk({tag, ".cnt_d"}, 32'(bus.cnt_d), 32'(m_d));
        chk({tag, ".cnt_q"}, 32'(bus.cnt_q), 32'(m_q));
    endtask

    // Inventory load from IDLE; called on a negedge, returns on a negedge.
    task automatic load(input int n, input int d, input int q, input string tag);
        bus.inv_ld = 1'b1;
        bus.inv_n  = 4'(n);
        bus.inv_d  = 4'(d);
        bus.inv_q  = 4'(q);
        @(negedge clk);
        bus.inv_ld = 1'b0;
        m_n = n;
        m_d = d;
        m_q = q;
        chk_inv(tag);
        chk({tag, ".ready"}, 32'(bus.ready), 32'd1);
    endtask

    // Full payout: greedy change computed as whole counts per coin, then
    // expanded into the expected pulse timeline (coin k at cycle 1+2k).
    task automatic pay(input int a, input string tag);
        int         r;
        int         nq;
        int         nd;
        int         nn;
        int         t;
        int         dc;
        logic [2:0] seq[$];
        logic [2:0] exp_p;
        r  = a;
        nq = imin(m_q, r / 5);  r = r - 5 * nq;
        nd = imin(m_d, r / 2);  r = r - 2 * nd;
        nn = imin(m_n, r);      r = r - nn;
        seq = {};
        for (int i = 0; i < nq; i++) seq.push_back(3'b100);
        for (int i = 0; i < nd; i++) seq.push_back(3'b010);
        for (int i = 0; i < nn; i++) seq.push_back(3'b001);
        t  = nq + nd + nn;
        dc = (a == 0) ? 1 : 2 * t + 2;

        chk({tag, ".ready_pre"}, 32'(bus.ready), 32'd1);
        bus.req = 1'b1;
        bus.amt = 5'(a);
        @(negedge clk);
        bus.req = 1'b0;
        bus.amt = 5'($urandom_range(0, 31));
        for (int c = 1; c <= dc + 1; c++) begin
            @(negedge clk);
            exp_p = 3'b000;
            if ((c % 2 == 1) && ((c - 1) / 2 < t)) exp_p = seq[(c - 1) / 2];
            chk($sformatf("%s.pulse@%0d", tag, c), 32'({bus.pq, bus.pd, bus.pn}), 32'(exp_p));
            chk($sformatf("%s.done@%0d", tag, c), 32'(bus.done), 32'(c == dc));
            chk($sformatf("%s.ready@%0d", tag, c), 32'(bus.ready), 32'(c >= dc));
            if (c == dc) begin
                m_q = m_q - nq;
                m_d = m_d - nd;
                m_n = m_n - nn;
                chk({tag, ".short"}, 32'(bus.short), 32'(r > 0));
                chk({tag, ".rem"}, 32'(bus.rem), 32'(r));
                chk_inv(tag);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        m_n = 0; m_d = 0; m_q = 0;
        rst_       = 1'b0;
        bus.req    = 1'b0;
        bus.amt    = 5'd0;
        bus.inv_ld = 1'b0;
        bus.inv_n  = 4'd0;
        bus.inv_d  = 4'd0;
        bus.inv_q  = 4'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(bus.ready), 32'd1);
        chk("rst.pulses", 32'({bus.pq, bus.pd, bus.pn}), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.short", 32'(bus.short), 32'd0);
        chk("rst.rem", 32'(bus.rem), 32'd0);
        chk_inv("rst");
        rst_ = 1'b1;
        @(negedge clk);

        // 7 = Q + D.
        load(3, 3, 3, "ld333");
        pay(7, "amt7");

        // Only two nickels for 5: short by 3.
        load(2, 0, 0, "ld_n2");
        pay(5, "amt5_short");

        // Zero amount completes immediately.
        pay(0, "amt0");

        // Load and req together: load wins, req is dropped.
        bus.inv_ld = 1'b1;
        bus.inv_n  = 4'd5;
        bus.inv_d  = 4'd6;
        bus.inv_q  = 4'd7;
        bus.req    = 1'b1;
        bus.amt    = 5'd9;
        @(negedge clk);
        bus.inv_ld = 1'b0;
        bus.req    = 1'b0;
        m_n = 5; m_d = 6; m_q = 7;
        chk_inv("ldreq");
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("ldreq.ready@%0d", c), 32'(bus.ready), 32'd1);
            chk($sformatf("ldreq.pulse@%0d", c), 32'({bus.pq, bus.pd, bus.pn, bus.done}), 32'd0);
            @(negedge clk);
        end

        // Reset during the GAP of an amt=10 payout.
        load(3, 3, 3, "ld_rst");
        bus.req = 1'b1;
        bus.amt = 5'd10;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        chk("midrst.first_pq", 32'({bus.pq, bus.pd, bus.pn}), 32'b100);
        rst_ = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        m_n = 0; m_d = 0; m_q = 0;
        chk("midrst.ready", 32'(bus.ready), 32'd1);
        chk("midrst.outs", 32'({bus.pq, bus.pd, bus.pn, bus.done, bus.short}), 32'd0);
        chk("midrst.rem", 32'(bus.rem), 32'd0);
        chk_inv("midrst");
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("midrst.quiet@%0d", c), 32'({bus.pq, bus.pd, bus.pn, bus.done}), 32'd0);
        end

        // 5 from dimes and one nickel: D, D, N.
        load(1, 4, 0, "ld_d4n1");
        pay(5, "amt5_ddn");

        // Randomized loads and payouts.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                load($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $sformatf("rld%0d", i));
            end
            pay(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31), $sformatf("rpay%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
